// File: rtl/skid_buffer_pkg.sv
// Shared types for the two-entry skid buffer: state encoding and occupancy decode.
package skid_buffer_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    // Encoding 2'b11 is unreachable and reads as empty.
    function automatic logic [1:0] skid_occupancy(input logic [1:0] state);
        logic [1:0] occ;
        occ = 2'd0;
        case (state)
            SKID_BUSY: occ = 2'd1;
            SKID_FULL: occ = 2'd2;
            default:   occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/register.sv
// Generic enabled register with asynchronous active-low reset to a parameterised value.
// Latency: 1 cycle from i_d to o_q when i_en is high.
// Backpressure: none; o_q holds whenever i_en is low.
module register #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/skid_buffer.sv
// Two-entry elastic stage between a producer and a consumer, one word per cycle.
// Latency: a word accepted at edge N is on qout from edge N (visible cycle N+1).
// Backpressure: din_ready drops only when both entries are full; decoded from state alone.
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] qout,
    output logic             qout_valid,
    input  logic             qout_ready,
    output logic [1:0]       occupancy
);

    logic [1:0]       w_state_q;
    logic [1:0]       w_state_d;
    logic             w_state_en;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_main_d;
    logic             w_main_en;
    logic             w_main_sel_skid;
    logic [WIDTH-1:0] w_skid_q;
    logic             w_skid_en;
    logic             w_in_xfer;
    logic             w_out_xfer;

    register #(
        .WIDTH     (2),
        .RESET_VAL (SKID_EMPTY)
    ) state_r (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .i_en      (w_state_en),
        .i_d       (w_state_d),
        .o_q       (w_state_q)
    );

    register #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) main_data_r (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .i_en      (w_main_en),
        .i_d       (w_main_d),
        .o_q       (w_main_q)
    );

    register #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) skid_data_r (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .i_en      (w_skid_en),
        .i_d       (din),
        .o_q       (w_skid_q)
    );

    // Handshake outputs come only from the state register, so neither ready
    // nor valid has a combinational path through this stage.
    always_comb begin
        din_ready  = 1'b1;
        qout_valid = 1'b0;
        case (w_state_q)
            SKID_BUSY: begin
                qout_valid = 1'b1;
            end
            SKID_FULL: begin
                din_ready  = 1'b0;
                qout_valid = 1'b1;
            end
            default: begin
                din_ready  = 1'b1;
                qout_valid = 1'b0;
            end
        endcase
    end

    assign occupancy  = skid_occupancy(w_state_q);
    assign qout       = w_main_q;
    assign w_in_xfer  = din_valid && din_ready;
    assign w_out_xfer = qout_valid && qout_ready;

    always_comb begin
        w_state_d       = w_state_q;
        w_main_en       = 1'b0;
        w_main_sel_skid = 1'b0;
        w_skid_en       = 1'b0;
        case (w_state_q)
            SKID_BUSY: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_en = 1'b1;
                end else if (w_in_xfer) begin
                    w_skid_en = 1'b1;
                    w_state_d = SKID_FULL;
                end else if (w_out_xfer) begin
                    // main keeps its stale word; nothing is cleared on drain
                    w_state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (w_out_xfer) begin
                    w_main_en       = 1'b1;
                    w_main_sel_skid = 1'b1;
                    w_state_d       = SKID_BUSY;
                end
            end
            default: begin
                w_state_d = SKID_EMPTY;
                if (w_in_xfer) begin
                    w_main_en = 1'b1;
                    w_state_d = SKID_BUSY;
                end
            end
        endcase
    end

    assign w_main_d   = w_main_sel_skid ? w_skid_q : din;
    assign w_state_en = (w_state_d != w_state_q);

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: directed scenarios plus randomized valid/ready
// against a queue-based reference model.
module tb_skid_buffer;

    localparam int          WIDTH = 32;
    localparam logic [31:0] RV    = 32'h0000_5A5A;

    logic        clk = 1'b0;
    logic        arst_n_in = 1'b1;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [31:0] qout;
    logic        qout_valid;
    logic        qout_ready = 1'b0;
    logic [1:0]  occupancy;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    logic [31:0] mq[$];
    logic [31:0] stale = RV;

    skid_buffer #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RV)
    ) dut (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .qout       (qout),
        .qout_valid (qout_valid),
        .qout_ready (qout_ready),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic dv, input logic qr);
        din        = d;
        din_valid  = dv;
        qout_ready = qr;
    endtask

    // Reference model: a FIFO of at most two words; qout shows the head, or
    // the last word that left once the buffer is empty.
    initial begin
        forever begin
            @(posedge clk or negedge arst_n_in);
            if (!arst_n_in) begin
                mq.delete();
                stale = RV;
            end else begin
                bit in_x;
                bit out_x;
                in_x  = din_valid && (mq.size() < 2);
                out_x = qout_ready && (mq.size() > 0);
                if (out_x) stale = mq.pop_front();
                if (in_x) mq.push_back(din);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("m_occ",  32'(occupancy),  32'(mq.size()));
                check("m_rdy",  32'(din_ready),  32'(mq.size() < 2));
                check("m_vld",  32'(qout_valid), 32'(mq.size() > 0));
                check("m_qout", qout, (mq.size() > 0) ? mq[0] : stale);
            end
        end
    end

    initial begin
        logic r0;
        int   pv;
        int   pr;
        #1 arst_n_in = 1'b0;
        #1 chk_en = 1'b1;
        check("rst_rdy",  32'(din_ready),  32'd1);
        check("rst_vld",  32'(qout_valid), 32'd0);
        check("rst_occ",  32'(occupancy),  32'd0);
        check("rst_qout", qout, RV);
        repeat (3) @(posedge clk);
        #1 arst_n_in = 1'b1;

        repeat (5) begin
            tick();
            check("idle_rdy", 32'(din_ready),  32'd1);
            check("idle_vld", 32'(qout_valid), 32'd0);
            check("idle_occ", 32'(occupancy),  32'd0);
        end

        for (int i = 1; i <= 8; i++) begin
            drive(32'(i), 1'b1, 1'b1);
            tick();
            check("stream_qout", qout, 32'(i));
            check("stream_occ",  32'(occupancy), 32'd1);
            check("stream_rdy",  32'(din_ready), 32'd1);
        end
        drive('0, 1'b0, 1'b1);
        tick();
        check("stream_end_occ", 32'(occupancy), 32'd0);

        drive(32'hA, 1'b1, 1'b0);
        tick();
        drive(32'hB, 1'b1, 1'b0);
        tick();
        check("bp_occ",  32'(occupancy), 32'd2);
        check("bp_rdy",  32'(din_ready), 32'd0);
        check("bp_qout", qout, 32'hA);
        drive(32'hC, 1'b1, 1'b0);
        tick();
        check("bp_c_occ",  32'(occupancy), 32'd2);
        check("bp_c_qout", qout, 32'hA);

        drive('0, 1'b0, 1'b1);
        check("drain0_qout", qout, 32'hA);
        check("drain0_occ",  32'(occupancy), 32'd2);
        tick();
        check("drain1_qout", qout, 32'hB);
        check("drain1_occ",  32'(occupancy), 32'd1);
        tick();
        check("drain2_vld",  32'(qout_valid), 32'd0);
        check("drain2_occ",  32'(occupancy), 32'd0);
        check("drain2_stale", qout, 32'hB);
        tick();

        pv = 50;
        pr = 50;
        for (int c = 0; c < 10000; c++) begin
            logic qr;
            if (c % 500 == 0) begin
                pv = int'($urandom_range(10, 95));
                pr = int'($urandom_range(10, 95));
            end
            @(posedge clk);
            #1;
            qr        = ($urandom_range(0, 99) < pr);
            din       = $urandom;
            din_valid = ($urandom_range(0, 99) < pv);
            qout_ready = ~qr;
            #1;
            r0 = din_ready;
            qout_ready = qr;
            #1;
            if (c % 10 == 0) check("comb_rdy", 32'(din_ready), 32'(r0));
        end

        tick();
        drive('0, 1'b0, 1'b1);
        repeat (3) tick();
        check("pre_mid_occ", 32'(occupancy), 32'd0);

        drive(32'h5, 1'b1, 1'b0);
        tick();
        drive(32'h6, 1'b1, 1'b0);
        tick();
        check("mid_full_occ", 32'(occupancy), 32'd2);
        check("mid_full_qout", qout, 32'h5);
        drive('0, 1'b0, 1'b0);
        #1 arst_n_in = 1'b0;
        #1;
        check("mid_rst_vld",  32'(qout_valid), 32'd0);
        check("mid_rst_occ",  32'(occupancy),  32'd0);
        check("mid_rst_qout", qout, RV);
        check("mid_rst_rdy",  32'(din_ready),  32'd1);
        #1 arst_n_in = 1'b1;
        tick();
        drive(32'h7, 1'b1, 1'b0);
        tick();
        check("post_qout", qout, 32'h7);
        check("post_occ",  32'(occupancy), 32'd1);
        drive('0, 1'b0, 1'b1);
        tick();
        check("post_vld", 32'(qout_valid), 32'd0);
        check("post_occ0", 32'(occupancy), 32'd0);
        check("post_stale", qout, 32'h7);
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
